// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    localparam int MAX_LEN_D = 8;
    localparam int LEN_W     = $clog2(MAX_LEN_D + 1);

    localparam logic [7:0] DEF_PATTERN = 8'b0001_0110;
    localparam int         DEF_LEN     = 5;
    localparam bit         DEF_OVERLAP = 1'b1;

    // Low-order ones mask covering the active pattern bits (max_len <= 32).
    function automatic logic [31:0] len_mask(input int len, input int max_len);
        int l;
        l = (len > max_len) ? max_len : len;
        if (l >= 32)
            return '1;
        return (32'd1 << l) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream, configuration and status bundle of the sequence detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               count_clear;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [LW-1:0]      fill_level;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern,
        output cfg_len, cfg_overlap, count_clear,
        input  match, match_count, fill_level
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern,
        input  cfg_len, cfg_overlap, count_clear,
        output match, match_count, fill_level
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= inc ? W'(1) : '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with registered match pulse,
// fill tracking and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int                 DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter bit                 DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input logic                 clock,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    import seq_det_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LW-1:0]      fill_q;
    logic               match_q;

    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_inc;
    logic [LW-1:0]      len_ld;
    logic               hit;

    always_comb begin
        hist_n   = {hist_q[MAX_LEN-2:0], bus.in_bit};
        fill_inc = (fill_q == MAXL) ? fill_q : fill_q + LW'(1);
        mask     = MAX_LEN'(len_mask(int'(len_q), MAX_LEN));
        len_ld   = (bus.cfg_len > MAXL) ? MAXL : bus.cfg_len;
        // A load in the same cycle drops the bit, so it can never hit.
        hit      = bus.in_valid && !bus.cfg_load
                   && (len_q != '0) && (fill_inc >= len_q)
                   && (((hist_n ^ pattern_q) & mask) == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (bus.cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= len_ld;
            overlap_q <= bus.cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (bus.in_valid) begin
            hist_q  <= hist_n;
            fill_q  <= (hit && !overlap_q) ? '0 : fill_inc;
            match_q <= hit;
        end else begin
            match_q <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.count_clear),
        .count (bus.match_count)
    );

    assign bus.match      = match_q;
    assign bus.fill_level = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param.
module tb_seq_detector_param;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    logic [15:0] stream = 16'b0101101101110010;

    always #5 clock = ~clock;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic cycle(input logic v, input logic b, input logic ld);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.cfg_load = ld;
        @(posedge clock);
        #1;
    endtask

    task automatic cycle2(input logic v, input logic b, input logic ld,
                          input logic clr);
        @(negedge clock);
        bus2.in_valid    = v;
        bus2.in_bit      = b;
        bus2.cfg_load    = ld;
        bus2.count_clear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l,
                        input logic o);
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        cycle(1'b0, 1'b0, 1'b1);
        bus.cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
        bus.count_clear = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.match !== 1'b0 || bus.fill_level !== 4'd0
            || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset: match=%0b fill=%0d count=%0d required 0 0 0",
                     bus.match, bus.fill_level, bus.match_count);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, stream[i], 1'b0);
            checks++;
            if (bus.match !== ((i == 10) || (i == 13))) begin
                errors++;
                $display("FAIL overlap bit %0d: match=%0b required %0b",
                         i, bus.match, (i == 10) || (i == 13));
            end
        end
        checks++;
        if (bus.match_count !== 8'd2 || bus.fill_level !== 4'd8) begin
            errors++;
            $display("FAIL overlap count/fill: %0d/%0d required 2/8",
                     bus.match_count, bus.fill_level);
        end
    endtask

    task automatic test_nonoverlap();
        do_reset();
        load(8'b0001_0110, 4'd5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, stream[i], 1'b0);
            checks++;
            if (bus.match !== (i == 10)) begin
                errors++;
                $display("FAIL nonoverlap bit %0d: match=%0b required %0b",
                         i, bus.match, i == 10);
            end
        end
        checks++;
        if (bus.match_count !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap count: %0d required 1", bus.match_count);
        end
    endtask

    task automatic test_gaps();
        logic [4:0] p;
        p = 5'b10110;
        do_reset();
        for (int k = 4; k >= 0; k--) begin
            cycle(1'b1, p[k], 1'b0);
            checks++;
            if (bus.match !== (k == 0)) begin
                errors++;
                $display("FAIL gaps bit %0d: match=%0b required %0b",
                         k, bus.match, k == 0);
            end
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.match !== 1'b0) begin
                errors++;
                $display("FAIL gaps idle %0d: match=%0b required 0",
                         k, bus.match);
            end
        end
        checks++;
        if (bus.match_count !== 8'd1) begin
            errors++;
            $display("FAIL gaps count: %0d required 1", bus.match_count);
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        bus.cfg_pattern = 8'b0001_0110;
        bus.cfg_len     = 4'd5;
        bus.cfg_overlap = 1'b1;
        cycle(1'b1, 1'b0, 1'b1);
        bus.cfg_load = 1'b0;
        checks++;
        if (bus.match !== 1'b0 || bus.fill_level !== 4'd0
            || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL load_priority: match=%0b fill=%0d count=%0d required 0 0 0",
                     bus.match, bus.fill_level, bus.match_count);
        end
    endtask

    task automatic test_len1();
        logic [3:0] b;
        logic [3:0] e;
        b = 4'b1011;
        e = 4'b1011;
        do_reset();
        load(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, b[i], 1'b0);
            checks++;
            if (bus.match !== e[i]) begin
                errors++;
                $display("FAIL len1 bit %0d: match=%0b required %0b",
                         i, bus.match, e[i]);
            end
        end
        checks++;
        if (bus.match_count !== 8'd3) begin
            errors++;
            $display("FAIL len1 count: %0d required 3", bus.match_count);
        end
    endtask

    task automatic test_len0();
        int seen;
        seen = 0;
        do_reset();
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, stream[i], 1'b0);
            if (bus.match !== 1'b0)
                seen++;
        end
        checks++;
        if (seen != 0 || bus.match_count !== 8'd0 || bus.fill_level !== 4'd8) begin
            errors++;
            $display("FAIL len0: pulses=%0d count=%0d fill=%0d required 0 0 8",
                     seen, bus.match_count, bus.fill_level);
        end
    endtask

    task automatic test_len_clamp();
        logic [15:0] s;
        s = 16'b1100110111001101;
        do_reset();
        load(8'b1011_0011, 4'd15, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, s[i], 1'b0);
            checks++;
            if (bus.match !== ((i == 7) || (i == 15))) begin
                errors++;
                $display("FAIL clamp bit %0d: match=%0b required %0b",
                         i, bus.match, (i == 7) || (i == 15));
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [6];
        exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus2.cfg_pattern = 8'h01;
        bus2.cfg_len     = 4'd1;
        bus2.cfg_overlap = 1'b1;
        cycle2(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle2(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus2.match_count !== exp[i]) begin
                errors++;
                $display("FAIL sat step %0d: count=%0d required %0d",
                         i, bus2.match_count, exp[i]);
            end
        end
        cycle2(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus2.match_count !== 2'd1) begin
            errors++;
            $display("FAIL sat clear+hit: count=%0d required 1", bus2.match_count);
        end
        cycle2(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus2.match_count !== 2'd0) begin
            errors++;
            $display("FAIL sat clear: count=%0d required 0", bus2.match_count);
        end
        cycle2(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [4:0] p;
        p = 5'b10110;
        do_reset();
        for (int k = 4; k >= 1; k--)
            cycle(1'b1, p[k], 1'b0);
        checks++;
        if (bus.fill_level !== 4'd4) begin
            errors++;
            $display("FAIL areset prefill: fill=%0d required 4", bus.fill_level);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.match !== 1'b0 || bus.fill_level !== 4'd0) begin
            errors++;
            $display("FAIL areset partial: match=%0b fill=%0d required 0 0",
                     bus.match, bus.fill_level);
        end
        #1 reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.match !== 1'b0) begin
            errors++;
            $display("FAIL areset tail: match=%0b required 0", bus.match);
        end
        do_reset();
        for (int k = 4; k >= 0; k--)
            cycle(1'b1, p[k], 1'b0);
        checks++;
        if (bus.match !== 1'b1 || bus.match_count !== 8'd1) begin
            errors++;
            $display("FAIL areset prematch: match=%0b count=%0d required 1 1",
                     bus.match, bus.match_count);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.match !== 1'b0 || bus.match_count !== 8'd0
            || bus.fill_level !== 4'd0) begin
            errors++;
            $display("FAIL areset live: match=%0b count=%0d fill=%0d required 0 0 0",
                     bus.match, bus.match_count, bus.fill_level);
        end
        #1 reset = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.cfg_load = 1'b0;
        bus.cfg_pattern = 8'h00;
        bus.cfg_len = 4'd0;
        bus.cfg_overlap = 1'b0;
        bus.count_clear = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_bit = 1'b0;
        bus2.cfg_load = 1'b0;
        bus2.cfg_pattern = 8'h00;
        bus2.cfg_len = 4'd0;
        bus2.cfg_overlap = 1'b0;
        bus2.count_clear = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_load_priority();
        test_len1();
        test_len0();
        test_len_clamp();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial-bit sequence detector; successor to the fixed 5-bit "10110" Mealy detector.
- Pattern, length and overlap mode are runtime-loadable, up to MAX_LEN bits.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial input stream and feeds a match pulse plus count to downstream control or status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 8'b0001_0110, reset pattern (right-aligned: "10110").
- DEF_LEN, 5, reset pattern length.
- DEF_OVERLAP, 1, reset overlap mode (1 = overlapping matches allowed).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_bit for this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  latch cfg_* fields on this edge.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  overlap mode.
- count_clear  in  1  synchronous clear of match_count.
- match  out  1  registered one-cycle pulse on detection.
- match_count  out  CNT_W  saturating number of matches.
- fill_level  out  $clog2(MAX_LEN+1)  valid history bits, saturating at MAX_LEN.

Behaviour:
- Reset (async, active-high):
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - history=0, fill=0, match=0, match_count=0.
- Per-edge priority:
  - 1. cfg_load: latch pattern/len/overlap, clear history and fill, match<=0. An in_valid bit in the same cycle is dropped. match_count is unaffected.
  - 2. else if in_valid:
    - history <= {history[MAX_LEN-2:0], in_bit}.
    - fill <= min(fill+1, MAX_LEN).
    - Evaluate detection on the new history (see below).
  - 3. else: history and fill hold, match<=0.
- Detection, evaluated on the updated history and fill:
  - hit = (fill_new >= len) and (history_new[len-1:0] == pattern[len-1:0]), using a len-derived mask.
  - match <= hit, so match is high for exactly the cycle after the edge that sampled the completing bit. Latency is 1 clock, same as the predecessor's registered output.
  - overlap=1: history and fill are retained after a hit.
  - overlap=0: on a hit, fill <= 0. The next match needs len fresh bits; the history contents may remain.
- Length rules:
  - cfg_len=0 latches a disabled detector: no match ever; history and fill still update.
  - cfg_len>MAX_LEN is clamped to MAX_LEN at load.
  - Pattern bits above len-1 are ignored.
- Counter:
  - Increments on each hit and saturates at 2^CNT_W-1 (no wrap).
  - count_clear together with a hit gives match_count=1; otherwise count_clear gives 0.
- Idle and mid-stream events:
  - in_valid=0 gaps do not break a partial match; only valid bits advance the history.
  - Reset mid-stream discards any partial match immediately; outputs go to their reset values asynchronously.
  - cfg_load mid-stream restarts detection with the new pattern; no match can be produced from pre-load bits.

Decomposition:
- Package seq_det_pkg holds:
  - Default constants DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
  - A length-to-mask function: mask = (1<<len)-1, clamped.
  - The clog2-derived width constant.
- One sub-module is natural: sat_counter (CNT_W param; inc, clr inputs; clear-then-increment semantics) for match_count.
- History, fill and compare stay in the top module.

Test Plan:
- Defaults, overlap: after reset, valid bits LSB-first of 16'b0101101101110010 (0,1,0,0,1,1,1,0,1,1,0,1,1,0,1,0) -> match pulses after bit indices 10 and 13; match_count=2.
- Non-overlap: load pattern 5'b10110, len=5, overlap=0, then the same stream -> single match after bit 10; match_count=1.
- Gaps and load priority:
  - Insert in_valid=0 cycles between each bit of "10110" -> exactly one match after the final valid bit.
  - Assert cfg_load in the cycle of the last bit -> no match; fill_level=0.
- Length edges:
  - len=1, pattern 1; bits 1,1,0,1 -> match after bits 0, 1 and 3.
  - len=0 -> no match for any stream.
  - cfg_len=15 with MAX_LEN=8 -> behaves as len=8.
- Counter saturation: CNT_W=2, pattern len=1 "1", six valid 1s -> match_count sequence 1,2,3,3,3,3. count_clear together with a hit -> 1.
- Async reset mid-match: after "1011" assert reset between edges -> match=0, fill_level=0 immediately; a following "0" does not match.
